// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
//
// Purpose:
//   Sits after the MAC array controller. Each MAC_o_valid delivers one psum
//   vector (MAC_NUM signed lanes). Over pass_num passes the vectors are either
//   summed (conv, saturating) or max-reduced (pooling) per lane. The finished
//   lanes are then streamed out over an AXI-Stream master, OUT_LANES lanes per
//   beat, towards the ofmap output DMA.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   MAC_out         psum vector, lane i at [i*PSUM_WIDTH +: PSUM_WIDTH]
//   MAC_o_valid     single-cycle qualifier for MAC_out
//   operation       2'd1 = max-pool, anything else = conv sum
//   pass_num        passes per result (0 behaves as 1), sampled on first pass
//   relu_en         clamp negative lanes to zero on the output only
//   acc_clear       abort / restart; highest priority, acts as soft reset
//   acc_ready       high while psum vectors are being accepted
//   m_axis_*        AXI-Stream master (tdata, tvalid, tready, tlast)
//   acc_done        one-cycle pulse after the final beat handshake
//   sat_flag        sticky: a conv lane saturated
//   drop_err        sticky: MAC_o_valid arrived while acc_ready was low
// ---------------------------------------------------------------------------
module psum_accumulator #(
    parameter int MAC_NUM        = 256,
    parameter int PSUM_WIDTH     = 6,
    parameter int ACC_WIDTH      = 16,
    parameter int OUT_LANES      = 8,
    parameter int PASS_CNT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [PSUM_WIDTH*MAC_NUM-1:0]   MAC_out,
    input  logic                            MAC_o_valid,
    input  logic [1:0]                      operation,
    input  logic [PASS_CNT_WIDTH-1:0]       pass_num,
    input  logic                            relu_en,
    input  logic                            acc_clear,
    output logic                            acc_ready,
    output logic [ACC_WIDTH*OUT_LANES-1:0]  m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            acc_done,
    output logic                            sat_flag,
    output logic                            drop_err
);

    localparam int NUM_BEATS = MAC_NUM / OUT_LANES;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int LANE_W    = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;

    localparam logic [BEAT_W-1:0]         BEAT_ZERO = {BEAT_W{1'b0}};
    localparam logic [BEAT_W-1:0]         BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};
    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam logic [PASS_CNT_WIDTH-1:0] PASS_ZERO = {PASS_CNT_WIDTH{1'b0}};
    localparam logic [PASS_CNT_WIDTH-1:0] PASS_ONE  = {{(PASS_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0]      ACC_ZERO  = {ACC_WIDTH{1'b0}};
    localparam logic [ACC_WIDTH-1:0]      ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]      ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Saturating signed add. Result bit ACC_WIDTH flags saturation, the low
    // ACC_WIDTH bits carry the (possibly clamped) sum.
    function automatic logic [ACC_WIDTH:0] f_sat_add(
        input logic [ACC_WIDTH-1:0] a,
        input logic [ACC_WIDTH-1:0] b
    );
        logic [ACC_WIDTH:0] sum;
        sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            f_sat_add = {1'b1, (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
        end else begin
            f_sat_add = {1'b0, sum[ACC_WIDTH-1:0]};
        end
    endfunction

    // Sign-extend one psum lane to accumulator width.
    function automatic logic [ACC_WIDTH-1:0] f_sext(input logic [PSUM_WIDTH-1:0] p);
        f_sext = {{(ACC_WIDTH-PSUM_WIDTH){p[PSUM_WIDTH-1]}}, p};
    endfunction

    // Registers
    state_t                      r_state;
    logic [PASS_CNT_WIDTH-1:0]   r_pass_cnt;
    logic [PASS_CNT_WIDTH-1:0]   r_pass_target;
    logic                        r_op_max;
    logic [BEAT_W-1:0]           r_beat_cnt;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic                        r_acc_done;
    logic                        r_acc_ready;
    logic                        r_sat_flag;
    logic                        r_drop_err;
    logic [ACC_WIDTH-1:0]        r_acc [MAC_NUM];

    // Combinational helpers
    logic                        w_accept;
    logic                        w_first;
    logic                        w_op_max;
    logic [PASS_CNT_WIDTH-1:0]   w_target;
    logic [PASS_CNT_WIDTH-1:0]   w_pass_idx;
    logic                        w_last_pass;
    logic [MAC_NUM-1:0]          w_lane_sat;
    logic                        w_sat_any;
    logic [ACC_WIDTH-1:0]        w_acc_next [MAC_NUM];

    // A vector is taken in ACC, or in any state when acc_clear restarts the
    // result in the same cycle (that vector becomes the new first pass).
    assign w_accept    = MAC_o_valid & (acc_clear | (r_state == ST_ACC));
    assign w_first     = acc_clear | (r_pass_cnt == PASS_ZERO);

    // Mode and pass count come from the inputs only on the first pass; later
    // passes use the latched copies so mid-result changes are ignored.
    assign w_op_max    = w_first ? (operation == 2'd1) : r_op_max;
    assign w_target    = w_first ? ((pass_num == PASS_ZERO) ? PASS_ONE : pass_num)
                                 : r_pass_target;
    assign w_pass_idx  = (w_first ? PASS_ZERO : r_pass_cnt) + PASS_ONE;
    assign w_last_pass = (w_pass_idx == w_target);
    assign w_sat_any   = w_accept & (|w_lane_sat);

    // Per-lane next accumulator value: overwrite, saturating add or max.
    for (genvar g = 0; g < MAC_NUM; g++) begin : g_lane
        logic [ACC_WIDTH-1:0] w_psum_ext;
        logic [ACC_WIDTH:0]   w_add;
        logic [ACC_WIDTH-1:0] w_max;

        assign w_psum_ext    = f_sext(MAC_out[g*PSUM_WIDTH +: PSUM_WIDTH]);
        assign w_add         = f_sat_add(r_acc[g], w_psum_ext);
        assign w_max         = ($signed(w_psum_ext) > $signed(r_acc[g])) ? w_psum_ext : r_acc[g];
        assign w_acc_next[g] = w_first  ? w_psum_ext :
                               w_op_max ? w_max      : w_add[ACC_WIDTH-1:0];
        assign w_lane_sat[g] = ~w_first & ~w_op_max & w_add[ACC_WIDTH];
    end

    // Output lane mux: beat_cnt selects OUT_LANES accumulators; relu is applied
    // here only, so the stored value stays signed.
    for (genvar j = 0; j < OUT_LANES; j++) begin : g_out
        logic [LANE_W-1:0]    w_idx;
        logic [ACC_WIDTH-1:0] w_val;

        assign w_idx = LANE_W'(r_beat_cnt) * LANE_W'(OUT_LANES) + LANE_W'(j);
        assign w_val = r_acc[w_idx];
        assign m_axis_tdata[j*ACC_WIDTH +: ACC_WIDTH] =
            (relu_en && w_val[ACC_WIDTH-1]) ? ACC_ZERO : w_val;
    end

    // Accumulator bank: updated only when a psum vector is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAC_NUM; i++) begin
                r_acc[i] <= ACC_ZERO;
            end
        end else if (w_accept) begin
            r_acc <= w_acc_next;
        end else begin
            r_acc <= r_acc;
        end
    end

    // Control FSM: pass counting, drain sequencing, handshake outputs, flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ACC;
            r_pass_cnt    <= PASS_ZERO;
            r_pass_target <= PASS_ONE;
            r_op_max      <= 1'b0;
            r_beat_cnt    <= BEAT_ZERO;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_acc_done    <= 1'b0;
            r_acc_ready   <= 1'b1;
            r_sat_flag    <= 1'b0;
            r_drop_err    <= 1'b0;
        end else begin
            r_acc_done <= 1'b0;

            // Sticky flags; acc_clear wipes them and suppresses a drop report.
            if (acc_clear) begin
                r_sat_flag <= 1'b0;
                r_drop_err <= 1'b0;
            end else begin
                r_sat_flag <= r_sat_flag | w_sat_any;
                r_drop_err <= r_drop_err | (MAC_o_valid & (r_state != ST_ACC));
            end

            if (w_accept) begin
                if (w_first) begin
                    r_pass_target <= w_target;
                    r_op_max      <= w_op_max;
                end else begin
                    r_pass_target <= r_pass_target;
                    r_op_max      <= r_op_max;
                end
                r_beat_cnt <= BEAT_ZERO;
                if (w_last_pass) begin
                    // Final pass: beat 0 is presented on the very next cycle.
                    r_pass_cnt  <= PASS_ZERO;
                    r_state     <= ST_DRAIN;
                    r_tvalid    <= 1'b1;
                    r_tlast     <= (LAST_BEAT == BEAT_ZERO);
                    r_acc_ready <= 1'b0;
                end else begin
                    r_pass_cnt  <= w_pass_idx;
                    r_state     <= ST_ACC;
                    r_tvalid    <= 1'b0;
                    r_tlast     <= 1'b0;
                    r_acc_ready <= 1'b1;
                end
            end else if (acc_clear) begin
                r_state     <= ST_ACC;
                r_pass_cnt  <= PASS_ZERO;
                r_beat_cnt  <= BEAT_ZERO;
                r_tvalid    <= 1'b0;
                r_tlast     <= 1'b0;
                r_acc_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_ACC: begin
                        r_state     <= ST_ACC;
                        r_acc_ready <= 1'b1;
                    end
                    ST_DRAIN: begin
                        if (r_tvalid && m_axis_tready) begin
                            if (r_beat_cnt == LAST_BEAT) begin
                                r_beat_cnt  <= BEAT_ZERO;
                                r_state     <= ST_ACC;
                                r_tvalid    <= 1'b0;
                                r_tlast     <= 1'b0;
                                r_acc_done  <= 1'b1;
                                r_acc_ready <= 1'b1;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + BEAT_ONE;
                                r_tlast    <= ((r_beat_cnt + BEAT_ONE) == LAST_BEAT);
                            end
                        end else begin
                            // Stalled: beat index and tlast hold.
                            r_beat_cnt <= r_beat_cnt;
                            r_tlast    <= r_tlast;
                        end
                    end
                    default: begin
                        r_state     <= ST_ACC;
                        r_pass_cnt  <= PASS_ZERO;
                        r_beat_cnt  <= BEAT_ZERO;
                        r_tvalid    <= 1'b0;
                        r_tlast     <= 1'b0;
                        r_acc_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign acc_ready     = r_acc_ready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign acc_done      = r_acc_done;
    assign sat_flag      = r_sat_flag;
    assign drop_err      = r_drop_err;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator. Two instances share all inputs: one with
// 16-bit accumulators and one with 8-bit accumulators (for saturation).
module tb_psum_accumulator;

    localparam int MAC_NUM   = 16;
    localparam int PSUM_W    = 6;
    localparam int OUT_LANES = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [MAC_NUM*PSUM_W-1:0]  mac_out;
    logic                       mac_valid;
    logic [1:0]                 operation;
    logic [7:0]                 pass_num;
    logic                       relu_en;
    logic                       acc_clear;
    logic                       tready;

    logic        ready16, tvalid16, tlast16, done16, sat16, drop16;
    logic [63:0] tdata16;
    logic        ready8, tvalid8, tlast8, done8, sat8, drop8;
    logic [31:0] tdata8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    psum_accumulator #(
        .MAC_NUM(MAC_NUM), .PSUM_WIDTH(PSUM_W), .ACC_WIDTH(16),
        .OUT_LANES(OUT_LANES), .PASS_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .MAC_out(mac_out), .MAC_o_valid(mac_valid),
        .operation(operation), .pass_num(pass_num), .relu_en(relu_en),
        .acc_clear(acc_clear), .acc_ready(ready16), .m_axis_tdata(tdata16),
        .m_axis_tvalid(tvalid16), .m_axis_tready(tready), .m_axis_tlast(tlast16),
        .acc_done(done16), .sat_flag(sat16), .drop_err(drop16)
    );

    psum_accumulator #(
        .MAC_NUM(MAC_NUM), .PSUM_WIDTH(PSUM_W), .ACC_WIDTH(8),
        .OUT_LANES(OUT_LANES), .PASS_CNT_WIDTH(8)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .MAC_out(mac_out), .MAC_o_valid(mac_valid),
        .operation(operation), .pass_num(pass_num), .relu_en(relu_en),
        .acc_clear(acc_clear), .acc_ready(ready8), .m_axis_tdata(tdata8),
        .m_axis_tvalid(tvalid8), .m_axis_tready(tready), .m_axis_tlast(tlast8),
        .acc_done(done8), .sat_flag(sat8), .drop_err(drop8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [5:0] v);
        mac_out = {MAC_NUM{v}};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mac_valid = 1'b0; operation = 2'd0; pass_num = 8'd0;
        relu_en = 1'b0; acc_clear = 1'b0; tready = 1'b0; fill(6'd0);
        tick(); tick();
        n_cmp++;
        if ({tvalid16, tlast16, done16, sat16, drop16, ready16} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset16: got %b, expected 000001", {tvalid16, tlast16, done16, sat16, drop16, ready16});
        end
        n_cmp++;
        if ({tvalid8, tlast8, done8, sat8, drop8, ready8} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset8: got %b, expected 000001", {tvalid8, tlast8, done8, sat8, drop8, ready8});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_conv_sum();
        pass_num = 8'd3; operation = 2'd0; relu_en = 1'b0; tready = 1'b1; fill(6'd5);
        for (int p = 0; p < 3; p++) begin
            n_cmp++;
            if (ready16 !== 1'b1 || tvalid16 !== 1'b0) begin
                n_err++;
                $display("FAIL conv_pass%0d: ready=%b tvalid=%b, expected ready=1 tvalid=0", p, ready16, tvalid16);
            end
            mac_valid = 1'b1;
            tick();
        end
        mac_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (tvalid16 !== 1'b1 || ready16 !== 1'b0 || done16 !== 1'b0 ||
                tdata16 !== {4{16'h000F}} || tlast16 !== (k == 3) || tdata8 !== {4{8'h0F}}) begin
                n_err++;
                $display("FAIL conv_beat%0d: tvalid=%b ready=%b done=%b tdata=%h tdata8=%h tlast=%b, expected 1 0 0 %h %h %b",
                         k, tvalid16, ready16, done16, tdata16, tdata8, tlast16, {4{16'h000F}}, {4{8'h0F}}, (k == 3));
            end
            tick();
        end
        n_cmp++;
        if (done16 !== 1'b1 || ready16 !== 1'b1 || tvalid16 !== 1'b0) begin
            n_err++;
            $display("FAIL conv_done: done=%b ready=%b tvalid=%b, expected 1 1 0", done16, ready16, tvalid16);
        end
        tick();
        n_cmp++;
        if (done16 !== 1'b0) begin
            n_err++;
            $display("FAIL conv_done_pulse: done=%b, expected 0", done16);
        end
    endtask

    task automatic test_relu();
        logic [63:0] exp_data;
        for (int r = 0; r < 2; r++) begin
            relu_en = (r == 1); pass_num = 8'd2; operation = 2'd0; tready = 1'b1; fill(6'h3D);
            exp_data = (r == 1) ? 64'h0 : {4{16'hFFFA}};
            mac_valid = 1'b1; tick(); tick(); mac_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (tvalid16 !== 1'b1 || tdata16 !== exp_data) begin
                    n_err++;
                    $display("FAIL relu%0d_beat%0d: tvalid=%b tdata=%h, expected 1 %h", r, k, tvalid16, tdata16, exp_data);
                end
                tick();
            end
            tick();
        end
        relu_en = 1'b0;
    endtask

    task automatic test_saturation();
        pass_num = 8'd5; operation = 2'd0; relu_en = 1'b0; tready = 1'b1; fill(6'h1F);
        mac_valid = 1'b1;
        for (int p = 0; p < 5; p++) tick();
        mac_valid = 1'b0;
        n_cmp++;
        if (sat8 !== 1'b1 || sat16 !== 1'b0) begin
            n_err++;
            $display("FAIL sat_set: sat8=%b sat16=%b, expected 1 0", sat8, sat16);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (tdata8 !== {4{8'h7F}} || tdata16 !== {4{16'h009B}}) begin
                n_err++;
                $display("FAIL sat_beat%0d: tdata8=%h tdata16=%h, expected %h %h", k, tdata8, tdata16, {4{8'h7F}}, {4{16'h009B}});
            end
            tick();
        end
        n_cmp++;
        if (sat8 !== 1'b1) begin
            n_err++;
            $display("FAIL sat_sticky: sat8=%b, expected 1", sat8);
        end
        acc_clear = 1'b1; tick(); acc_clear = 1'b0;
        n_cmp++;
        if (sat8 !== 1'b0) begin
            n_err++;
            $display("FAIL sat_clear: sat8=%b, expected 0", sat8);
        end
    endtask

    task automatic test_maxpool();
        logic [5:0]  vals [2][3];
        logic [15:0] exps [2];
        vals[0][0] = 6'd3;  vals[0][1] = 6'h39; vals[0][2] = 6'd12;   exps[0] = 16'h000C;
        vals[1][0] = 6'h3C; vals[1][1] = 6'h37; vals[1][2] = 6'h3E;   exps[1] = 16'hFFFE;
        operation = 2'd1; pass_num = 8'd3; tready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mac_valid = 1'b1;
            for (int p = 0; p < 3; p++) begin
                fill(vals[s][p]);
                tick();
            end
            mac_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (tvalid16 !== 1'b1 || tdata16 !== {4{exps[s]}}) begin
                    n_err++;
                    $display("FAIL max%0d_beat%0d: tvalid=%b tdata=%h, expected 1 %h", s, k, tvalid16, tdata16, {4{exps[s]}});
                end
                tick();
            end
            tick();
        end
        operation = 2'd0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_data;
        int v;
        operation = 2'd0; pass_num = 8'd0; tready = 1'b1;
        for (int i = 0; i < MAC_NUM; i++) mac_out[i*PSUM_W +: PSUM_W] = 6'(i - 8);
        mac_valid = 1'b1; tick(); mac_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            relu_en = (k % 2 == 1);
            #1;
            for (int j = 0; j < OUT_LANES; j++) begin
                v = k * OUT_LANES + j - 8;
                exp_data[j*16 +: 16] = (relu_en && v < 0) ? 16'h0 : 16'(v);
            end
            n_cmp++;
            if (tvalid16 !== 1'b1 || tdata16 !== exp_data || tlast16 !== (k == 3)) begin
                n_err++;
                $display("FAIL order_beat%0d: tvalid=%b tdata=%h tlast=%b, expected 1 %h %b", k, tvalid16, tdata16, tlast16, exp_data, (k == 3));
            end
            tick();
        end
        relu_en = 1'b0;
        n_cmp++;
        if (ready16 !== 1'b1 || done16 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: ready=%b done=%b, expected 1 1", ready16, done16);
        end
        fill(6'd7); mac_valid = 1'b1; tick(); mac_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (tvalid16 !== 1'b1 || tdata16 !== {4{16'h0007}} || tlast16 !== (k == 3)) begin
                n_err++;
                $display("FAIL b2b_beat%0d: tvalid=%b tdata=%h tlast=%b, expected 1 %h %b", k, tvalid16, tdata16, tlast16, {4{16'h0007}}, (k == 3));
            end
            tick();
        end
        tick();
    endtask

    task automatic test_stall_drop();
        logic [63:0] exp_data;
        logic hs;
        int k;
        int cyc;
        operation = 2'd0; pass_num = 8'd1; relu_en = 1'b0; tready = 1'b0;
        for (int i = 0; i < MAC_NUM; i++) mac_out[i*PSUM_W +: PSUM_W] = 6'(i + 1);
        mac_valid = 1'b1; tick(); mac_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 200) begin
            tready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            mac_valid = (cyc % 3 == 0);
            fill(6'h21);
            for (int j = 0; j < OUT_LANES; j++) exp_data[j*16 +: 16] = 16'(k * OUT_LANES + j + 1);
            n_cmp++;
            if (tvalid16 !== 1'b1 || ready16 !== 1'b0 || tdata16 !== exp_data || tlast16 !== (k == 3)) begin
                n_err++;
                $display("FAIL stall_cyc%0d: tvalid=%b ready=%b tdata=%h tlast=%b, expected 1 0 %h %b",
                         cyc, tvalid16, ready16, tdata16, tlast16, exp_data, (k == 3));
            end
            hs = tready;
            tick();
            if (hs) k++;
            cyc++;
        end
        mac_valid = 1'b0; tready = 1'b1;
        n_cmp++;
        if (k != 4 || done16 !== 1'b1 || drop16 !== 1'b1) begin
            n_err++;
            $display("FAIL stall_end: beats=%0d done=%b drop=%b, expected 4 1 1", k, done16, drop16);
        end
        acc_clear = 1'b1; tick(); acc_clear = 1'b0;
        n_cmp++;
        if (drop16 !== 1'b0) begin
            n_err++;
            $display("FAIL drop_clear: drop=%b, expected 0", drop16);
        end
    endtask

    task automatic test_reset_clear();
        operation = 2'd0; pass_num = 8'd1; tready = 1'b1; fill(6'd9);
        mac_valid = 1'b1; tick();
        tick();
        mac_valid = 1'b0; tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tvalid16, tlast16, done16, sat16, drop16, ready16} !== 6'b000001) begin
            n_err++;
            $display("FAIL mid_reset: got %b, expected 000001", {tvalid16, tlast16, done16, sat16, drop16, ready16});
        end
        tick(); rst_n = 1'b1; tick();
        pass_num = 8'd3; fill(6'd10);
        mac_valid = 1'b1; tick(); tick();
        acc_clear = 1'b1; fill(6'd4); tick(); acc_clear = 1'b0;
        n_cmp++;
        if (ready16 !== 1'b1 || tvalid16 !== 1'b0 || drop16 !== 1'b0) begin
            n_err++;
            $display("FAIL clear_valid: ready=%b tvalid=%b drop=%b, expected 1 0 0", ready16, tvalid16, drop16);
        end
        pass_num = 8'd7;
        fill(6'd5); tick();
        fill(6'd6); tick();
        mac_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (tvalid16 !== 1'b1 || tdata16 !== {4{16'h000F}}) begin
                n_err++;
                $display("FAIL clear_beat%0d: tvalid=%b tdata=%h, expected 1 %h", k, tvalid16, tdata16, {4{16'h000F}});
            end
            tick();
        end
        n_cmp++;
        if (done16 !== 1'b1) begin
            n_err++;
            $display("FAIL clear_done: done=%b, expected 1", done16);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_conv_sum();
        test_relu();
        test_saturation();
        test_maxpool();
        test_back_to_back();
        test_stall_drop();
        test_reset_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
